// File: rtl/bcd_counter_pkg.sv
// Shared constants and digit helpers for the multi-digit modulo counter.
//   MAX_NDIG / MAX_MOD : legal parameter limits
//   MAX_DW             : widest digit (MOD=16 -> 4 bits)
//   is_max(d, mod)     : digit sits at its top value (mod-1)
//   is_over(d, mod)    : digit is outside the legal range (>= mod)
package bcd_counter_pkg;
  localparam int MAX_NDIG = 8;
  localparam int MAX_MOD  = 16;
  localparam int MAX_DW   = 4;

  function automatic logic is_max(input logic [MAX_DW-1:0] digit, input int mod);
    return int'(digit) == (mod - 1);
  endfunction

  function automatic logic is_over(input logic [MAX_DW-1:0] digit, input int mod);
    return int'(digit) >= mod;
  endfunction
endpackage

// File: rtl/bcd_digit.sv
// One modulo-MOD digit of the cascaded counter.
//   clk, rst  : clock, async active-high reset
//   step      : advance one position this edge (carry/borrow already resolved)
//   up        : direction of the step
//   clr, load : synchronous clear / parallel load (clr wins)
//   ld_val    : load value; out-of-range values are clamped to MOD-1
//   q         : current digit value
//   at_max    : q == MOD-1 (feeds the up-carry chain)
//   at_min    : q == 0     (feeds the down-borrow chain)
module bcd_digit
  import bcd_counter_pkg::*;
#(
  parameter int MOD = 10,
  parameter int DW  = $clog2(MOD)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          step,
  input  logic          up,
  input  logic          clr,
  input  logic          load,
  input  logic [DW-1:0] ld_val,
  output logic [DW-1:0] q,
  output logic          at_max,
  output logic          at_min
);
  localparam logic [DW-1:0] MAXV = DW'(MOD - 1);

  logic [DW-1:0] r_q;
  logic [DW-1:0] w_ld_fix;

  // Clamp keeps the digit inside 0..MOD-1 even after a bad load.
  assign w_ld_fix = is_over(MAX_DW'(ld_val), MOD) ? MAXV : ld_val;
  assign at_max   = is_max(MAX_DW'(r_q), MOD);
  assign at_min   = (r_q == '0);
  assign q        = r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_q <= '0;
    else if (clr)  r_q <= '0;
    else if (load) r_q <= w_ld_fix;
    else if (step) begin
      if (up) r_q <= at_max ? '0   : r_q + 1'b1;
      else    r_q <= at_min ? MAXV : r_q - 1'b1;
    end
  end
endmodule

// File: rtl/bcd_counter_n.sv
// Parametrised multi-digit modulo counter (NDIG digits, each modulo MOD).
//   clk, rst  : clock, async active-high reset
//   en, up    : count enable and direction, sampled together
//   clr, load : synchronous clear / parallel load; priority clr > load > en
//   load_val  : load value, digit k = load_val[k*DW +: DW]
//   cnt       : current count, digit 0 least significant
//   cout      : 1-cycle pulse on wrap (SATURATE=0) or on a blocked step at the limit (SATURATE=1)
//   load_err  : 1-cycle pulse when a load had to clamp any digit
module bcd_counter_n
  import bcd_counter_pkg::*;
#(
  parameter int NDIG     = 2,
  parameter int MOD      = 10,
  parameter bit SATURATE = 1'b0,
  localparam int DW      = $clog2(MOD)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               up,
  input  logic               clr,
  input  logic               load,
  input  logic [NDIG*DW-1:0] load_val,
  output logic [NDIG*DW-1:0] cnt,
  output logic               cout,
  output logic               load_err
);
  if (NDIG < 1 || NDIG > MAX_NDIG || MOD < 2 || MOD > MAX_MOD) begin : g_bad_param
    $error("bcd_counter_n: NDIG must be 1..%0d and MOD 2..%0d", MAX_NDIG, MAX_MOD);
  end

  logic [NDIG-1:0] w_at_max, w_at_min, w_step, w_dig_over;
  // w_cy[k]: digits 0..k-1 all at max; w_bw[k]: digits 0..k-1 all at zero.
  logic [NDIG:0]   w_cy, w_bw;
  logic            w_limit, w_cnt_en;
  logic            r_cout, r_load_err;

  assign w_cy[0] = 1'b1;
  assign w_bw[0] = 1'b1;

  for (genvar k = 0; k < NDIG; k++) begin : g_dig
    assign w_cy[k+1]     = w_cy[k] & w_at_max[k];
    assign w_bw[k+1]     = w_bw[k] & w_at_min[k];
    assign w_step[k]     = w_cnt_en & (up ? w_cy[k] : w_bw[k]);
    assign w_dig_over[k] = is_over(MAX_DW'(load_val[k*DW +: DW]), MOD);

    bcd_digit #(.MOD(MOD), .DW(DW)) u_dig (
      .clk    (clk),
      .rst    (rst),
      .step   (w_step[k]),
      .up     (up),
      .clr    (clr),
      .load   (load),
      .ld_val (load_val[k*DW +: DW]),
      .q      (cnt[k*DW +: DW]),
      .at_max (w_at_max[k]),
      .at_min (w_at_min[k])
    );
  end

  // Whole counter sits at the limit for the requested direction.
  assign w_limit  = up ? w_cy[NDIG] : w_bw[NDIG];
  // In saturate mode a step at the limit is suppressed so every digit holds.
  assign w_cnt_en = en & ~clr & ~load & ~(SATURATE & w_limit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cout     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_cout     <= ~clr & ~load & en & w_limit;
      r_load_err <= ~clr & load & (|w_dig_over);
    end
  end

  assign cout     = r_cout;
  assign load_err = r_load_err;
endmodule

// File: tb/tb_bcd_counter_n.sv
// Scoreboard bench for bcd_counter_n. Three instances share one stimulus stream:
//   u0: NDIG=2 MOD=10 wrap, u1: NDIG=2 MOD=10 saturate, u2: NDIG=3 MOD=16 wrap.
// The reference keeps each counter as a plain integer in 0..MOD**NDIG-1.
module tb_bcd_counter_n;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0, up = 1'b0, clr = 1'b0, load = 1'b0;
  logic [31:0] lv = '0;
  logic [7:0]  cnt0, cnt1;
  logic [11:0] cnt2;
  logic [2:0]  cout_o, lerr_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bcd_counter_n #(.NDIG(2), .MOD(10), .SATURATE(1'b0)) u0 (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(lv[7:0]), .cnt(cnt0), .cout(cout_o[0]), .load_err(lerr_o[0]));
  bcd_counter_n #(.NDIG(2), .MOD(10), .SATURATE(1'b1)) u1 (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(lv[7:0]), .cnt(cnt1), .cout(cout_o[1]), .load_err(lerr_o[1]));
  bcd_counter_n #(.NDIG(3), .MOD(16), .SATURATE(1'b0)) u2 (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(lv[11:0]), .cnt(cnt2), .cout(cout_o[2]), .load_err(lerr_o[2]));

  typedef struct packed {
    logic [2:0][31:0] cnt;
    logic [2:0]       cout;
    logic [2:0]       lerr;
  } exp_t;

  exp_t q[$];
  exp_t m_e;

  int cfg_nd [3] = '{2, 2, 3};
  int cfg_mod[3] = '{10, 10, 16};
  int cfg_sat[3] = '{0, 1, 0};
  int mval   [3] = '{0, 0, 0};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference: counter value as an integer, digits only formed for display.
  function automatic void model(input int i, input logic e, u, c, l, input logic [31:0] v,
                                output logic [31:0] ocnt, output logic oc, output logic ol);
    int m   = cfg_mod[i];
    int dw  = $clog2(m);
    int top = 1;
    int p   = 1;
    for (int k = 0; k < cfg_nd[i]; k++) top *= m;
    oc = 1'b0;
    ol = 1'b0;
    if (c) mval[i] = 0;
    else if (l) begin
      mval[i] = 0;
      for (int k = 0; k < cfg_nd[i]; k++) begin
        int d = int'((v >> (k * dw)) & ((32'd1 << dw) - 1));
        if (d >= m) begin d = m - 1; ol = 1'b1; end
        mval[i] += d * p;
        p *= m;
      end
    end else if (e) begin
      if (u) begin
        if (mval[i] == top - 1) begin oc = 1'b1; if (cfg_sat[i] == 0) mval[i] = 0; end
        else mval[i]++;
      end else begin
        if (mval[i] == 0) begin oc = 1'b1; if (cfg_sat[i] == 0) mval[i] = top - 1; end
        else mval[i]--;
      end
    end
    ocnt = '0;
    p = 1;
    for (int k = 0; k < cfg_nd[i]; k++) begin
      ocnt |= 32'((mval[i] / p) % m) << (k * dw);
      p *= m;
    end
  endfunction

  task automatic drive(input logic e, u, c, l, input logic [31:0] v);
    exp_t x;
    @(negedge clk);
    en = e; up = u; clr = c; load = l; lv = v;
    for (int i = 0; i < 3; i++) model(i, e, u, c, l, v, x.cnt[i], x.cout[i], x.lerr[i]);
    q.push_back(x);
  endtask

  // Monitor: outputs are valid every cycle; compare once the edge has settled.
  always @(posedge clk) begin
    #1;
    if (!rst && q.size() > 0) begin
      m_e = q.pop_front();
      chk("u0.cnt",  {24'd0, cnt0}, m_e.cnt[0]);
      chk("u1.cnt",  {24'd0, cnt1}, m_e.cnt[1]);
      chk("u2.cnt",  {20'd0, cnt2}, m_e.cnt[2]);
      chk("cout",    {29'd0, cout_o}, {29'd0, m_e.cout});
      chk("load_err",{29'd0, lerr_o}, {29'd0, m_e.lerr});
    end
  end

  task automatic chk_reset(input string nm);
    chk({nm, ".cnt0"}, {24'd0, cnt0}, 32'd0);
    chk({nm, ".cnt1"}, {24'd0, cnt1}, 32'd0);
    chk({nm, ".cnt2"}, {20'd0, cnt2}, 32'd0);
    chk({nm, ".flags"}, {26'd0, cout_o, lerr_o}, 32'd0);
  endtask

  initial begin
    #11 rst = 1'b0;
    chk_reset("reset");

    // Full up sweep 00..99 with wrap on the 100th edge.
    repeat (100) drive(1, 1, 0, 0, 0);
    // Load 09 then count down through the borrow and the underflow.
    drive(0, 0, 0, 1, 32'h009);
    repeat (11) drive(1, 0, 0, 0, 0);
    // Out-of-range load clamps.
    drive(0, 0, 0, 1, 32'h0AF);
    drive(0, 0, 0, 0, 0);
    // Saturation at the top and the bottom (u1), wrap on u0.
    drive(0, 0, 0, 1, 32'h098);
    repeat (3) drive(1, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 32'h000);
    repeat (2) drive(1, 0, 0, 0, 0);
    // All controls together: clear wins.
    drive(0, 0, 0, 1, 32'h057);
    drive(1, 1, 1, 1, 32'h0FF);
    // Three-digit hex wrap on u2.
    drive(0, 0, 0, 1, 32'hFFF);
    drive(1, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0);

    // Random traffic.
    for (int n = 0; n < 400; n++)
      drive(($urandom % 4) != 0, $urandom % 2, ($urandom % 25) == 0,
            ($urandom % 8) == 0, $urandom);

    // Asynchronous reset between edges at 0x42.
    drive(0, 0, 0, 1, 32'h041);
    drive(1, 1, 0, 0, 0);
    @(negedge clk);
    en = 1'b0; load = 1'b0; clr = 1'b0;
    #2 rst = 1'b1;
    #1 chk_reset("async_rst");
    for (int i = 0; i < 3; i++) mval[i] = 0;
    @(negedge clk) rst = 1'b0;
    repeat (5) drive(1, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0);

    repeat (2) @(posedge clk);
    #2;
    chk("queue_drained", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
